// File: rtl/batch_issue_sequencer.sv
// Walks one scheduled batch (SBR -> SRR chain -> request chain) and offers
// request IDs on a valid/ready issue port with row-open/row-close markers.
module batch_issue_sequencer #(
   parameter int REQ_ID_W = 6,
   parameter int SRR_ID_W = 5,
   parameter int SBR_ID_W = 4,
   parameter int RD_LAT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                flush,
   input  logic [SBR_ID_W-1:0] critical_sbr,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [REQ_ID_W-1:0] issued_count,
   output logic [SBR_ID_W-1:0] sbr_rd_addr,
   input  logic [SRR_ID_W-1:0] sbr_rd_head_srr,
   input  logic [SRR_ID_W-1:0] sbr_rd_row_count,
   input  logic [REQ_ID_W-1:0] sbr_rd_total_requests,
   output logic [SRR_ID_W-1:0] srr_rd_addr,
   input  logic [REQ_ID_W-1:0] srr_rd_head_req,
   input  logic [REQ_ID_W-1:0] srr_rd_count,
   input  logic [SRR_ID_W-1:0] srr_rd_next_srr,
   output logic [REQ_ID_W-1:0] req_rd_addr,
   input  logic [REQ_ID_W-1:0] req_rd_next_req,
   output logic                issue_valid,
   input  logic                issue_ready,
   output logic [REQ_ID_W-1:0] issue_req_id,
   output logic                issue_first_in_row,
   output logic                issue_last_in_row,
   output logic                issue_last
);

   localparam int WAIT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {IDLE, RD_SBR, RD_SRR, ISSUE, NEXT_REQ, DONE} state_t;

   state_t              state, state_d;
   logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
   logic [SRR_ID_W-1:0] rows_left, rows_left_d;
   logic [REQ_ID_W-1:0] reqs_left, reqs_left_d;
   logic [REQ_ID_W-1:0] total_reqs, total_reqs_d;
   logic [SRR_ID_W-1:0] next_srr, next_srr_d;

   logic                busy_d, done_d, error_d, issue_valid_d;
   logic [REQ_ID_W-1:0] issued_count_d, issue_req_id_d, req_rd_addr_d;
   logic [SBR_ID_W-1:0] sbr_rd_addr_d;
   logic [SRR_ID_W-1:0] srr_rd_addr_d;
   logic                first_d, last_in_row_d, last_d;
   logic [REQ_ID_W-1:0] count_inc;

   logic wait_done, handshake, abort;

   assign wait_done = (wait_cnt == WAIT_W'(RD_LAT));
   assign handshake = (state == ISSUE) && issue_valid && issue_ready;
   assign abort     = flush && (state != IDLE);
   assign count_inc = issued_count + REQ_ID_W'(1);

   // State register; every output is a flop so downstream sees clean edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         wait_cnt           <= '0;
         rows_left          <= '0;
         reqs_left          <= '0;
         total_reqs         <= '0;
         next_srr           <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         issued_count       <= '0;
         sbr_rd_addr        <= '0;
         srr_rd_addr        <= '0;
         req_rd_addr        <= '0;
         issue_valid        <= 1'b0;
         issue_req_id       <= '0;
         issue_first_in_row <= 1'b0;
         issue_last_in_row  <= 1'b0;
         issue_last         <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values together.
         state              <= state_d;
         wait_cnt           <= wait_cnt_d;
         rows_left          <= rows_left_d;
         reqs_left          <= reqs_left_d;
         total_reqs         <= total_reqs_d;
         next_srr           <= next_srr_d;
         busy               <= busy_d;
         done               <= done_d;
         error              <= error_d;
         issued_count       <= issued_count_d;
         sbr_rd_addr        <= sbr_rd_addr_d;
         srr_rd_addr        <= srr_rd_addr_d;
         req_rd_addr        <= req_rd_addr_d;
         issue_valid        <= issue_valid_d;
         issue_req_id       <= issue_req_id_d;
         issue_first_in_row <= first_d;
         issue_last_in_row  <= last_in_row_d;
         issue_last         <= last_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (start) state_d = RD_SBR;
         RD_SBR:   if (wait_done)
                      state_d = (sbr_rd_row_count == '0 || sbr_rd_total_requests == '0) ? DONE : RD_SRR;
         RD_SRR:   if (wait_done) state_d = (srr_rd_count == '0) ? DONE : ISSUE;
         ISSUE:    if (handshake) begin
                      if (issue_last)             state_d = DONE;
                      else if (issue_last_in_row) state_d = RD_SRR;
                      else                        state_d = NEXT_REQ;
                   end
         NEXT_REQ: if (wait_done) state_d = ISSUE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // Flush outranks start and handshake.
      if (abort) state_d = IDLE;
   end

   always_comb begin
      // NOTE: every target gets a default here, so no path can infer a latch.
      wait_cnt_d     = '0;
      rows_left_d    = rows_left;
      reqs_left_d    = reqs_left;
      total_reqs_d   = total_reqs;
      next_srr_d     = next_srr;
      error_d        = error;
      issued_count_d = issued_count;
      sbr_rd_addr_d  = sbr_rd_addr;
      srr_rd_addr_d  = srr_rd_addr;
      req_rd_addr_d  = req_rd_addr;
      issue_req_id_d = issue_req_id;
      first_d        = issue_first_in_row;
      last_in_row_d  = issue_last_in_row;
      last_d         = issue_last;
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == DONE);
      issue_valid_d  = (state_d == ISSUE);

      if (!abort) begin
         case (state)
            IDLE: if (start) begin
               sbr_rd_addr_d  = critical_sbr;
               issued_count_d = '0;
               error_d        = 1'b0;
            end
            RD_SBR: if (!wait_done) begin
               wait_cnt_d = wait_cnt + WAIT_W'(1);
            end else if (sbr_rd_row_count == '0 || sbr_rd_total_requests == '0) begin
               error_d = 1'b1;
            end else begin
               rows_left_d   = sbr_rd_row_count;
               total_reqs_d  = sbr_rd_total_requests;
               srr_rd_addr_d = sbr_rd_head_srr;
            end
            RD_SRR: if (!wait_done) begin
               wait_cnt_d = wait_cnt + WAIT_W'(1);
            end else if (srr_rd_count == '0) begin
               error_d = 1'b1;
            end else begin
               reqs_left_d    = srr_rd_count;
               next_srr_d     = srr_rd_next_srr;
               issue_req_id_d = srr_rd_head_req;
               first_d        = 1'b1;
               last_in_row_d  = (srr_rd_count == REQ_ID_W'(1));
               last_d         = (srr_rd_count == REQ_ID_W'(1)) && (rows_left == SRR_ID_W'(1));
            end
            ISSUE: if (handshake) begin
               issued_count_d = count_inc;
               reqs_left_d    = reqs_left - REQ_ID_W'(1);
               if (issue_last) begin
                  // A chain that disagrees with the SBR total is reported with done.
                  error_d = error || (count_inc != total_reqs);
               end else if (issue_last_in_row) begin
                  rows_left_d   = rows_left - SRR_ID_W'(1);
                  srr_rd_addr_d = next_srr;
               end else begin
                  req_rd_addr_d = issue_req_id;
               end
            end
            NEXT_REQ: if (!wait_done) begin
               wait_cnt_d = wait_cnt + WAIT_W'(1);
            end else begin
               issue_req_id_d = req_rd_next_req;
               first_d        = 1'b0;
               last_in_row_d  = (reqs_left == REQ_ID_W'(1));
               last_d         = (reqs_left == REQ_ID_W'(1)) && (rows_left == SRR_ID_W'(1));
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_batch_issue_sequencer.sv
// Directed bench for batch_issue_sequencer: models the three tables with
// RD_LAT read latency, drives issue_ready, and checks order, timing and errors.
module tb_batch_issue_sequencer;

   localparam int REQ_ID_W = 6;
   localparam int SRR_ID_W = 5;
   localparam int SBR_ID_W = 4;
   localparam int RD_LAT   = 2;

   logic                clk = 1'b0;
   logic                rst, start, flush;
   logic [SBR_ID_W-1:0] critical_sbr;
   logic                busy, done, error;
   logic [REQ_ID_W-1:0] issued_count;
   logic [SBR_ID_W-1:0] sbr_rd_addr;
   logic [SRR_ID_W-1:0] sbr_rd_head_srr, sbr_rd_row_count;
   logic [REQ_ID_W-1:0] sbr_rd_total_requests;
   logic [SRR_ID_W-1:0] srr_rd_addr;
   logic [REQ_ID_W-1:0] srr_rd_head_req, srr_rd_count;
   logic [SRR_ID_W-1:0] srr_rd_next_srr;
   logic [REQ_ID_W-1:0] req_rd_addr, req_rd_next_req;
   logic                issue_valid;
   logic                issue_ready = 1'b1;
   logic [REQ_ID_W-1:0] issue_req_id;
   logic                issue_first_in_row, issue_last_in_row, issue_last;

   batch_issue_sequencer #(
      .REQ_ID_W(REQ_ID_W), .SRR_ID_W(SRR_ID_W), .SBR_ID_W(SBR_ID_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .critical_sbr(critical_sbr),
      .busy(busy), .done(done), .error(error), .issued_count(issued_count),
      .sbr_rd_addr(sbr_rd_addr), .sbr_rd_head_srr(sbr_rd_head_srr),
      .sbr_rd_row_count(sbr_rd_row_count), .sbr_rd_total_requests(sbr_rd_total_requests),
      .srr_rd_addr(srr_rd_addr), .srr_rd_head_req(srr_rd_head_req),
      .srr_rd_count(srr_rd_count), .srr_rd_next_srr(srr_rd_next_srr),
      .req_rd_addr(req_rd_addr), .req_rd_next_req(req_rd_next_req),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_id(issue_req_id),
      .issue_first_in_row(issue_first_in_row), .issue_last_in_row(issue_last_in_row),
      .issue_last(issue_last)
   );

   always #5 clk = ~clk;

   // Table model: data follows the address after RD_LAT register stages.
   logic [SRR_ID_W-1:0] sbr_head [16];
   logic [SRR_ID_W-1:0] sbr_rows [16];
   logic [REQ_ID_W-1:0] sbr_total [16];
   logic [REQ_ID_W-1:0] srr_head [32];
   logic [REQ_ID_W-1:0] srr_count [32];
   logic [SRR_ID_W-1:0] srr_next [32];
   logic [REQ_ID_W-1:0] req_next [64];
   logic [SBR_ID_W-1:0] sbr_pipe [RD_LAT];
   logic [SRR_ID_W-1:0] srr_pipe [RD_LAT];
   logic [REQ_ID_W-1:0] req_pipe [RD_LAT];

   always @(posedge clk) begin
      sbr_pipe[0] <= sbr_rd_addr;
      srr_pipe[0] <= srr_rd_addr;
      req_pipe[0] <= req_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         sbr_pipe[i] <= sbr_pipe[i-1];
         srr_pipe[i] <= srr_pipe[i-1];
         req_pipe[i] <= req_pipe[i-1];
      end
   end

   assign sbr_rd_head_srr       = sbr_head[sbr_pipe[RD_LAT-1]];
   assign sbr_rd_row_count      = sbr_rows[sbr_pipe[RD_LAT-1]];
   assign sbr_rd_total_requests = sbr_total[sbr_pipe[RD_LAT-1]];
   assign srr_rd_head_req       = srr_head[srr_pipe[RD_LAT-1]];
   assign srr_rd_count          = srr_count[srr_pipe[RD_LAT-1]];
   assign srr_rd_next_srr       = srr_next[srr_pipe[RD_LAT-1]];
   assign req_rd_next_req       = req_next[req_pipe[RD_LAT-1]];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Ready driver and handshake monitor share one process to avoid races.
   int                  hs_q [$];
   int                  rise_q [$];
   logic [REQ_ID_W-1:0] id_q [$];
   logic [2:0]          mk_q [$];
   logic                valid_prev = 1'b0;
   int                  stall_left = 0;
   int                  stall_cycles = 0;
   int                  stable_bad = 0;
   logic [REQ_ID_W-1:0] stall_id = '0;
   logic [REQ_ID_W+2:0] snap;
   int                  done_seen = 0;
   int                  done_edge = 0;
   logic                done_err, done_busy;
   logic [REQ_ID_W-1:0] done_cnt;

   always @(negedge clk) begin
      if (issue_valid && stall_left > 0 && issue_req_id == stall_id) begin
         if (stall_cycles == 0)
            snap = {issue_req_id, issue_first_in_row, issue_last_in_row, issue_last};
         else if (snap != {issue_req_id, issue_first_in_row, issue_last_in_row, issue_last})
            stable_bad++;
         stall_cycles++;
         stall_left--;
         issue_ready = 1'b0;
      end else begin
         issue_ready = 1'b1;
      end
      if (issue_valid && !valid_prev) rise_q.push_back(cyc);
      if (issue_valid && issue_ready) begin
         hs_q.push_back(cyc + 1);
         id_q.push_back(issue_req_id);
         mk_q.push_back({issue_first_in_row, issue_last_in_row, issue_last});
      end
      if (done) begin
         done_seen++;
         done_edge = cyc;
         done_err  = error;
         done_cnt  = issued_count;
         done_busy = busy;
      end
      valid_prev = issue_valid;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      hs_q.delete();
      rise_q.delete();
      id_q.delete();
      mk_q.delete();
   endtask

   task automatic run_batch(input logic [SBR_ID_W-1:0] sbr, output int start_edge);
      int base;
      int n;
      base = done_seen;
      n = 0;
      clear_log();
      start = 1'b1;
      critical_sbr = sbr;
      start_edge = cyc + 1;
      tick();
      start = 1'b0;
      while (done_seen == base && n < 200) begin
         tick();
         n++;
      end
      check("done_pulse", done_seen - base, 1);
      check("busy_in_done", done_busy, 1'b1);
      tick();
      check("busy_after_done", busy, 1'b0);
      check("done_one_cycle", done, 1'b0);
   endtask

   logic [REQ_ID_W-1:0] exp_id [4] = '{6'd10, 6'd11, 6'd12, 6'd20};
   logic [2:0]          exp_mk [4] = '{3'b100, 3'b000, 3'b010, 3'b111};

   task automatic check_order(input int start_edge);
      check("hs_count", hs_q.size(), 4);
      for (int k = 0; k < 4 && k < id_q.size(); k++) begin
         check($sformatf("req_id%0d", k), id_q[k], exp_id[k]);
         check($sformatf("markers%0d", k), mk_q[k], exp_mk[k]);
      end
      if (rise_q.size() > 0) check("start_to_valid", rise_q[0] - start_edge, 6);
      else check("valid_seen", 0, 1);
      for (int k = 0; k < 3 && k + 1 < rise_q.size() && k < hs_q.size(); k++)
         check($sformatf("gap%0d", k), rise_q[k+1] - hs_q[k], 3);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"}, busy, 1'b0);
      check({pfx, "_done"}, done, 1'b0);
      check({pfx, "_error"}, error, 1'b0);
      check({pfx, "_count"}, issued_count, 0);
      check({pfx, "_sbr_addr"}, sbr_rd_addr, 0);
      check({pfx, "_srr_addr"}, srr_rd_addr, 0);
      check({pfx, "_req_addr"}, req_rd_addr, 0);
      check({pfx, "_valid"}, issue_valid, 1'b0);
      check({pfx, "_req_id"}, issue_req_id, 0);
      check({pfx, "_markers"}, {issue_first_in_row, issue_last_in_row, issue_last}, 3'b000);
   endtask

   initial begin
      int se;
      int n;
      int base;
      for (int i = 0; i < 16; i++) begin sbr_head[i] = '0; sbr_rows[i] = '0; sbr_total[i] = '0; end
      for (int i = 0; i < 32; i++) begin srr_head[i] = '0; srr_count[i] = '0; srr_next[i] = '0; end
      for (int i = 0; i < 64; i++) req_next[i] = '0;
      // SBR 3: rows SRR5 (10->11->12) then SRR7 (20), total 4.
      sbr_head[3] = 5'd5; sbr_rows[3] = 5'd2; sbr_total[3] = 6'd4;
      srr_head[5] = 6'd10; srr_count[5] = 6'd3; srr_next[5] = 5'd7;
      srr_head[7] = 6'd20; srr_count[7] = 6'd1; srr_next[7] = 5'd0;
      req_next[10] = 6'd11; req_next[11] = 6'd12; req_next[12] = 6'd40;
      // SBR 1: zero rows.  SBR 2: SRR with zero requests.  SBR 4: total overstated.
      sbr_head[1] = 5'd5; sbr_rows[1] = 5'd0; sbr_total[1] = 6'd4;
      sbr_head[2] = 5'd9; sbr_rows[2] = 5'd1; sbr_total[2] = 6'd3;
      srr_head[9] = 6'd30; srr_count[9] = 6'd0; srr_next[9] = 5'd0;
      sbr_head[4] = 5'd5; sbr_rows[4] = 5'd2; sbr_total[4] = 6'd5;

      rst = 1'b1; start = 1'b0; flush = 1'b0; critical_sbr = '0;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Clean two-row batch with ready always high.
      run_batch(4'd3, se);
      check_order(se);
      check("clean_error", done_err, 1'b0);
      check("clean_count", done_cnt, 4);
      if (hs_q.size() == 4) check("done_after_last_hs", done_edge, hs_q[3]);

      // Same batch, second request stalled for 5 cycles.
      stall_id = 6'd11; stall_left = 5; stall_cycles = 0; stable_bad = 0;
      run_batch(4'd3, se);
      check_order(se);
      check("stall_cycles", stall_cycles, 5);
      check("stall_stable", stable_bad, 0);
      check("stall_count", done_cnt, 4);
      check("stall_error", done_err, 1'b0);

      // Malformed tables.
      run_batch(4'd1, se);
      check("rows0_error", done_err, 1'b1);
      check("rows0_no_valid", rise_q.size(), 0);
      run_batch(4'd2, se);
      check("cnt0_error", done_err, 1'b1);
      check("cnt0_no_valid", rise_q.size(), 0);
      run_batch(4'd4, se);
      check("total_hs", hs_q.size(), 4);
      check("total_error", done_err, 1'b1);
      check("total_count", done_cnt, 4);

      // Flush while request 11 is pending.
      clear_log();
      base = done_seen;
      stall_id = 6'd11; stall_left = 50; stall_cycles = 0;
      start = 1'b1; critical_sbr = 4'd3;
      tick();
      start = 1'b0;
      n = 0;
      while (!(issue_valid && issue_req_id == 6'd11 && !issue_ready) && n < 100) begin
         tick();
         n++;
      end
      check("flush_reached", {issue_valid, issue_req_id}, {1'b1, 6'd11});
      flush = 1'b1;
      tick();
      flush = 1'b0;
      stall_left = 0;
      check("flush_valid", issue_valid, 1'b0);
      check("flush_busy", busy, 1'b0);
      check("flush_count", issued_count, 1);
      repeat (4) tick();
      check("flush_no_done", done_seen - base, 0);
      check("flush_idle", busy, 1'b0);
      run_batch(4'd3, se);
      check_order(se);
      check("post_flush_error", done_err, 1'b0);
      check("post_flush_count", done_cnt, 4);

      // Start held through the batch, then reset in NEXT_REQ.
      clear_log();
      start = 1'b1; critical_sbr = 4'd3;
      tick();
      critical_sbr = 4'd4;
      n = 0;
      while (hs_q.size() == 0 && n < 100) begin
         tick();
         n++;
      end
      tick();
      check("held_start_addr", sbr_rd_addr, 3);
      check("held_start_count", issued_count, 1);
      check("held_start_valid", issue_valid, 1'b0);
      rst = 1'b1; start = 1'b0;
      tick();
      check_zero("midrst");
      rst = 1'b0;
      repeat (3) tick();
      check("rst_stays_idle", {busy, issue_valid, done}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/batch_issue_sequencer.md
# batch_issue_sequencer

Sequences the issue of one scheduled batch to the DRAM command stage once the batch scheduler has built the SRR/SBR tables and chosen the critical-path SBR. It walks that SBR's SRR chain row by row, and within each row walks the request chain. It presents one request ID at a time on a valid/ready issue port, with row-open and row-close markers. It sits between the batch scheduler's tables and the command generator.

## Interface
Parameters:
- REQ_ID_W, 6, request ID / request count width
- SRR_ID_W, 5, SRR ID / row count width
- SBR_ID_W, 4, SBR ID width
- RD_LAT, 2, table read latency in cycles from address change to data valid (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a batch; accepted only in IDLE
- flush  in  1  abort current batch
- critical_sbr  in  SBR_ID_W  SBR to issue; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- error  out  1  valid with done: table inconsistency detected
- issued_count  out  REQ_ID_W  requests handshaked in current or last batch
- sbr_rd_addr  out  SBR_ID_W  SBR table read address
- sbr_rd_head_srr  in  SRR_ID_W  first SRR of SBR
- sbr_rd_row_count  in  SRR_ID_W  SRRs in SBR
- sbr_rd_total_requests  in  REQ_ID_W  requests in SBR
- srr_rd_addr  out  SRR_ID_W  SRR table read address
- srr_rd_head_req  in  REQ_ID_W  first request of SRR
- srr_rd_count  in  REQ_ID_W  requests in SRR
- srr_rd_next_srr  in  SRR_ID_W  SRR chain pointer
- req_rd_addr  out  REQ_ID_W  request buffer read address
- req_rd_next_req  in  REQ_ID_W  request chain pointer
- issue_valid  out  1  request offered
- issue_ready  in  1  command stage accepts
- issue_req_id  out  REQ_ID_W  offered request
- issue_first_in_row  out  1  first request of SRR (ACT needed)
- issue_last_in_row  out  1  last request of SRR (PRE allowed after)
- issue_last  out  1  last request of batch

## Operation
- States: IDLE, RD_SBR, RD_SRR, ISSUE, NEXT_REQ, DONE.
- IDLE: on start, latch critical_sbr. Drive sbr_rd_addr, clear issued_count and error, go to RD_SBR.
- RD_SBR: wait RD_LAT cycles, then latch head_srr, row_count and total_requests. If row_count==0 or total==0, set error and go to DONE. Otherwise rows_left=row_count, drive srr_rd_addr=head_srr, go to RD_SRR.
- RD_SRR: wait RD_LAT, then latch count, head_req and next_srr. If count==0, set error and go to DONE. Otherwise reqs_left=count, issue_req_id=head_req, first_in_row=1, go to ISSUE.
- ISSUE: issue_valid=1. last_in_row=(reqs_left==1). issue_last=last_in_row && rows_left==1. On handshake (valid&&ready):
  - Increment issued_count.
  - Decrement reqs_left.
  - If the request was last in batch, go to DONE.
  - Otherwise, if it was last in row, decrement rows_left, drive srr_rd_addr=latched next_srr, and go to RD_SRR.
  - Otherwise drive req_rd_addr=issue_req_id and go to NEXT_REQ.
- NEXT_REQ: wait RD_LAT, then issue_req_id=req_rd_next_req, first_in_row=0, go to ISSUE.
- DONE: pulse done. Set error additionally if issued_count != total_requests. Return to IDLE.
- flush in any non-IDLE state: go to IDLE next cycle. issue_valid drops (the only permitted valid withdrawal). No done pulse. issued_count holds.
- start outside IDLE is ignored. flush has priority over start and handshake in the same cycle.
- Counters are REQ_ID_W/SRR_ID_W wide and wrap modulo 2^W; no saturation. A total of 0 is treated as invalid, not as 2^W.

## Timing
- Reset values: every output 0, state IDLE.
- All outputs are registered. Address outputs change on the edge entering the wait state, and data is sampled on the RD_LAT-th subsequent edge.
- start→first issue_valid with RD_LAT=2: start sampled at edge 0, sbr data at edge 3, srr data at edge 6, issue_valid high after edge 6. That is 6 cycles, or 2×RD_LAT+2 in general.
- Within a row: handshake→next issue_valid is RD_LAT+1 cycles. Row change costs the same, RD_LAT+1.
- While valid and not ready, issue_req_id and all markers hold stable.
- done is asserted the cycle after the final handshake. busy falls the cycle after done. A new start is accepted in the cycle after done.
- rst mid-batch: all state returns to reset values on the next edge regardless of handshake.

## Test plan
- One SBR, 2 rows (counts 3, 1), ready always 1:
  - Required issue order: head0, n1, n2 (last_in_row), head1 (first, last_in_row, last).
  - Required done with error=0 and issued_count=4.
  - Required gaps between issues: 3 cycles.
- Same batch with ready low for 5 cycles on the second request → issue_req_id and markers stable for those 5 cycles; no extra handshake counted.
- row_count=0, or SRR count=0 → error=1 with done, no issue_valid ever asserted.
- total_requests=5 but chain counts sum to 4 → 4 issues, then done with error=1.
- flush asserted while issue_valid is pending on request 2 → issue_valid low the next cycle, no done, busy low, issued_count=1; a fresh start then runs cleanly.
- start held high during a batch, plus rst pulsed mid-NEXT_REQ → second start ignored; after rst, all outputs are 0 and state is IDLE.
